// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    FLUSH    = 2'd2
  } pipe_state_e;

  localparam logic [5:0] FUNCT_MUL   = 6'b000010;
  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID/EX observation inputs and stall/flush controls exchanged with the hazard sequencer.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  import pipe_ctrl_pkg::*;

  // No handshake: inputs are sampled every rising edge; outputs are combinational
  // from the registered state and the current inputs.
  logic [4:0]       id_rs_addr;
  logic [4:0]       id_rt_addr;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rd_addr;
  logic             ex_branch_taken;
  logic             ex_mul_start;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             ex_stall;
  logic             squash_ex_dm;
  logic             mul_done;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  pipe_state_e      state;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rd_addr,
           ex_branch_taken, ex_mul_start,
    input  pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, ex_stall,
           squash_ex_dm, mul_done, stall_count, flush_count, state
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rd_addr,
           ex_branch_taken, ex_mul_start,
    output pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush, ex_stall,
           squash_ex_dm, mul_done, stall_count, flush_count, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the sources of ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic       uses_rt,
  input  logic       mem_read,
  input  logic [4:0] rd_addr,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (rd_addr == rs_addr);
  assign rt_match = uses_rt && (rd_addr == rt_addr);
  // $0 is hard-wired, so a load targeting it can never feed a dependent.
  assign load_use = mem_read && (rd_addr != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, taken-branch squash, multi-cycle MUL hold.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int MC_W     = $clog2(MUL_LATENCY) + 1;
  localparam int MUL_LOAD = (MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0;

  pipe_state_e      state, state_n;
  logic [MC_W-1:0]  mul_cnt, mul_cnt_n;
  logic             load_use;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             ex_stall;
  logic             squash_ex_dm;
  logic             mul_done;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  hazard_detect u_hazard_detect (
    .rs_addr  (bus.id_rs_addr),
    .rt_addr  (bus.id_rt_addr),
    .uses_rt  (bus.id_uses_rt),
    .mem_read (bus.ex_mem_read),
    .rd_addr  (bus.ex_rd_addr),
    .load_use (load_use)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_n;
      mul_cnt <= mul_cnt_n;
    end
  end

  always_comb begin
    state_n        = state;
    mul_cnt_n      = mul_cnt;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_bubble   = 1'b0;
    if_id_flush    = 1'b0;
    ex_stall       = 1'b0;
    squash_ex_dm   = 1'b0;
    mul_done       = 1'b0;
    case (state)
      RUN: begin
        // Branch wins: anything else in flight is on the wrong path.
        if (bus.ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_n      = FLUSH;
        end else if (bus.ex_mul_start) begin
          if (MUL_LATENCY == 1) begin
            mul_done = 1'b1;
          end else begin
            ex_stall       = 1'b1;
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            mul_cnt_n      = MC_W'(MUL_LOAD);
            state_n        = MUL_WAIT;
          end
        end else if (load_use) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (mul_cnt != '0) begin
          ex_stall       = 1'b1;
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          mul_cnt_n      = mul_cnt - 1'b1;
        end else begin
          mul_done = 1'b1;
          state_n  = RUN;
        end
      end
      FLUSH: begin
        squash_ex_dm = 1'b1;
        state_n      = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // Performance counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write_en && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if ((state == RUN) && (state_n == FLUSH) && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.pc_write_en    = pc_write_en;
  assign bus.if_id_write_en = if_id_write_en;
  assign bus.id_ex_bubble   = id_ex_bubble;
  assign bus.if_id_flush    = if_id_flush;
  assign bus.ex_stall       = ex_stall;
  assign bus.squash_ex_dm   = squash_ex_dm;
  assign bus.mul_done       = mul_done;
  assign bus.stall_count    = stall_count;
  assign bus.flush_count    = flush_count;
  assign bus.state          = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: three controller builds (MUL_LATENCY 3 / 1, and a 4-bit counter build).
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) ia ();
  pipeline_hazard_ctrl_if #(.CNT_W(32)) ib ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  ic ();

  pipeline_hazard_ctrl #(.MUL_LATENCY(3), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  pipeline_hazard_ctrl #(.MUL_LATENCY(1), .CNT_W(32)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  pipeline_hazard_ctrl #(.MUL_LATENCY(3), .CNT_W(4))  dut_c (.clk(clk), .reset(reset), .bus(ic));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ia.id_rs_addr = 5'd0; ia.id_rt_addr = 5'd0; ia.id_uses_rt = 1'b0; ia.ex_mem_read = 1'b0;
    ia.ex_rd_addr = 5'd0; ia.ex_branch_taken = 1'b0; ia.ex_mul_start = 1'b0;
    ib.id_rs_addr = 5'd0; ib.id_rt_addr = 5'd0; ib.id_uses_rt = 1'b0; ib.ex_mem_read = 1'b0;
    ib.ex_rd_addr = 5'd0; ib.ex_branch_taken = 1'b0; ib.ex_mul_start = 1'b0;
    ic.id_rs_addr = 5'd0; ic.id_rt_addr = 5'd0; ic.id_uses_rt = 1'b0; ic.ex_mem_read = 1'b0;
    ic.ex_rd_addr = 5'd0; ic.ex_branch_taken = 1'b0; ic.ex_mul_start = 1'b0;
  endtask

  task automatic set_load_a(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                            input logic uses_rt);
    ia.ex_mem_read = 1'b1; ia.ex_rd_addr = rd; ia.id_rs_addr = rs;
    ia.id_rt_addr = rt; ia.id_uses_rt = uses_rt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    n_cmp++; if (ia.pc_write_en !== 1'b1) begin n_err++; $display("FAIL rst_pc: got %b want 1", ia.pc_write_en); end
    n_cmp++; if (ia.if_id_write_en !== 1'b1) begin n_err++; $display("FAIL rst_ifid: got %b want 1", ia.if_id_write_en); end
    n_cmp++; if ({ia.id_ex_bubble, ia.if_id_flush, ia.ex_stall, ia.squash_ex_dm, ia.mul_done} !== 5'b0)
      begin n_err++; $display("FAIL rst_flags: got %b want 00000",
        {ia.id_ex_bubble, ia.if_id_flush, ia.ex_stall, ia.squash_ex_dm, ia.mul_done}); end
    n_cmp++; if (ia.stall_count !== 32'd0 || ia.flush_count !== 32'd0) begin n_err++;
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", ia.stall_count, ia.flush_count); end
    n_cmp++; if (ic.stall_count !== 4'd0) begin n_err++; $display("FAIL rst_cnt_c: got %0d want 0", ic.stall_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    set_load_a(5'd5, 5'd5, 5'd0, 1'b0);
    #1;
    n_cmp++; if ({ia.pc_write_en, ia.if_id_write_en, ia.id_ex_bubble} !== 3'b001) begin n_err++;
      $display("FAIL lu_rs: got pc/ifid/bub=%b want 001", {ia.pc_write_en, ia.if_id_write_en, ia.id_ex_bubble}); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (ia.stall_count !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", ia.stall_count); end
    n_cmp++; if (ia.pc_write_en !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b want 1", ia.pc_write_en); end
    set_load_a(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    n_cmp++; if ({ia.pc_write_en, ia.id_ex_bubble} !== 2'b10) begin n_err++;
      $display("FAIL lu_r0: got pc/bub=%b want 10", {ia.pc_write_en, ia.id_ex_bubble}); end
    tick();
    clear_inputs();
    n_cmp++; if (ia.stall_count !== 32'd1) begin n_err++; $display("FAIL lu_r0_cnt: got %0d want 1", ia.stall_count); end
  endtask

  task automatic test_rt_only();
    set_load_a(5'd7, 5'd3, 5'd7, 1'b0);
    #1;
    n_cmp++; if (ia.pc_write_en !== 1'b1) begin n_err++; $display("FAIL rt_unused: got %b want 1", ia.pc_write_en); end
    ia.id_uses_rt = 1'b1;
    #1;
    n_cmp++; if ({ia.pc_write_en, ia.id_ex_bubble} !== 2'b01) begin n_err++;
      $display("FAIL rt_used: got pc/bub=%b want 01", {ia.pc_write_en, ia.id_ex_bubble}); end
    tick();
    clear_inputs();
    n_cmp++; if (ia.stall_count !== 32'd2) begin n_err++; $display("FAIL rt_cnt: got %0d want 2", ia.stall_count); end
  endtask

  // MUL start plus a competing load-use: MUL has priority, then the held start is ignored in MUL_WAIT.
  task automatic test_mul();
    ia.ex_mul_start = 1'b1;
    set_load_a(5'd4, 5'd4, 5'd0, 1'b0);
    #1;
    n_cmp++; if ({ia.ex_stall, ia.pc_write_en, ia.id_ex_bubble, ia.mul_done} !== 4'b1000) begin n_err++;
      $display("FAIL mul_c0: got stall/pc/bub/done=%b want 1000",
        {ia.ex_stall, ia.pc_write_en, ia.id_ex_bubble, ia.mul_done}); end
    tick();
    n_cmp++; if (ia.state !== MUL_WAIT || ia.ex_stall !== 1'b1 || ia.mul_done !== 1'b0) begin n_err++;
      $display("FAIL mul_c1: got state=%0d stall=%b done=%b want 1/1/0", ia.state, ia.ex_stall, ia.mul_done); end
    tick();
    n_cmp++; if ({ia.ex_stall, ia.pc_write_en, ia.if_id_write_en, ia.mul_done} !== 4'b0111) begin n_err++;
      $display("FAIL mul_c2: got stall/pc/ifid/done=%b want 0111",
        {ia.ex_stall, ia.pc_write_en, ia.if_id_write_en, ia.mul_done}); end
    clear_inputs();
    tick();
    n_cmp++; if (ia.state !== RUN || ia.mul_done !== 1'b0) begin n_err++;
      $display("FAIL mul_end: got state=%0d done=%b want 0/0", ia.state, ia.mul_done); end
    n_cmp++; if (ia.stall_count !== 32'd4) begin n_err++; $display("FAIL mul_cnt: got %0d want 4", ia.stall_count); end

    ib.ex_mul_start = 1'b1;
    #1;
    n_cmp++; if ({ib.mul_done, ib.ex_stall, ib.pc_write_en} !== 3'b101) begin n_err++;
      $display("FAIL mul1_c0: got done/stall/pc=%b want 101", {ib.mul_done, ib.ex_stall, ib.pc_write_en}); end
    tick();
    clear_inputs();
    n_cmp++; if (ib.state !== RUN || ib.stall_count !== 32'd0) begin n_err++;
      $display("FAIL mul1_end: got state=%0d cnt=%0d want 0/0", ib.state, ib.stall_count); end
  endtask

  task automatic test_branch_load_use();
    ia.ex_branch_taken = 1'b1;
    set_load_a(5'd9, 5'd9, 5'd0, 1'b0);
    #1;
    n_cmp++; if ({ia.if_id_flush, ia.pc_write_en, ia.id_ex_bubble, ia.squash_ex_dm} !== 4'b1110) begin n_err++;
      $display("FAIL br_c0: got flush/pc/bub/squash=%b want 1110",
        {ia.if_id_flush, ia.pc_write_en, ia.id_ex_bubble, ia.squash_ex_dm}); end
    tick();
    ia.ex_branch_taken = 1'b0;
    #1;
    n_cmp++; if ({ia.squash_ex_dm, ia.pc_write_en, ia.if_id_flush, ia.id_ex_bubble} !== 4'b1100) begin n_err++;
      $display("FAIL br_c1: got squash/pc/flush/bub=%b want 1100",
        {ia.squash_ex_dm, ia.pc_write_en, ia.if_id_flush, ia.id_ex_bubble}); end
    n_cmp++; if (ia.flush_count !== 32'd1) begin n_err++; $display("FAIL br_fcnt: got %0d want 1", ia.flush_count); end
    clear_inputs();
    tick();
    n_cmp++; if (ia.stall_count !== 32'd4 || ia.state !== RUN || ia.squash_ex_dm !== 1'b0) begin n_err++;
      $display("FAIL br_end: got scnt=%0d state=%0d squash=%b want 4/0/0", ia.stall_count, ia.state, ia.squash_ex_dm); end
  endtask

  task automatic test_reset_mid_mul();
    ia.ex_mul_start = 1'b1;
    tick();
    clear_inputs();
    reset = 1'b1;
    #1;
    n_cmp++; if ({ia.ex_stall, ia.pc_write_en, ia.if_id_write_en, ia.mul_done} !== 4'b0110) begin n_err++;
      $display("FAIL rmul_out: got stall/pc/ifid/done=%b want 0110",
        {ia.ex_stall, ia.pc_write_en, ia.if_id_write_en, ia.mul_done}); end
    n_cmp++; if (ia.state !== RUN || ia.stall_count !== 32'd0 || ia.flush_count !== 32'd0) begin n_err++;
      $display("FAIL rmul_state: got state=%0d scnt=%0d fcnt=%0d want 0/0/0", ia.state, ia.stall_count, ia.flush_count); end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (ia.mul_done !== 1'b0) begin n_err++; $display("FAIL rmul_nodone: got %b want 0", ia.mul_done); end
    ia.ex_mul_start = 1'b1;
    tick();
    clear_inputs();
    n_cmp++; if (ia.ex_stall !== 1'b1 || ia.mul_done !== 1'b0) begin n_err++;
      $display("FAIL rmul_again_c1: got stall=%b done=%b want 1/0", ia.ex_stall, ia.mul_done); end
    tick();
    n_cmp++; if (ia.mul_done !== 1'b1 || ia.ex_stall !== 1'b0) begin n_err++;
      $display("FAIL rmul_again_c2: got done=%b stall=%b want 1/0", ia.mul_done, ia.ex_stall); end
    tick();
    n_cmp++; if (ia.stall_count !== 32'd2) begin n_err++; $display("FAIL rmul_again_cnt: got %0d want 2", ia.stall_count); end
  endtask

  task automatic test_saturation();
    ic.ex_mem_read = 1'b1; ic.ex_rd_addr = 5'd12; ic.id_rs_addr = 5'd12;
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (ic.stall_count !== 4'hF) begin n_err++; $display("FAIL sat_15: got %0h want f", ic.stall_count); end
    tick(); tick();
    n_cmp++; if (ic.stall_count !== 4'hF) begin n_err++; $display("FAIL sat_hold: got %0h want f", ic.stall_count); end
    clear_inputs();
  endtask

  // two branches separated by the mandatory FLUSH cycle; a branch flag during FLUSH is ignored
  task automatic test_back_to_back();
    ia.ex_branch_taken = 1'b1;
    tick();
    n_cmp++; if (ia.squash_ex_dm !== 1'b1 || ia.if_id_flush !== 1'b0) begin n_err++;
      $display("FAIL b2b_flush: got squash=%b flush=%b want 1/0", ia.squash_ex_dm, ia.if_id_flush); end
    tick();
    n_cmp++; if (ia.if_id_flush !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %b want 1", ia.if_id_flush); end
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (ia.flush_count !== 32'd2) begin n_err++; $display("FAIL b2b_fcnt: got %0d want 2", ia.flush_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_rt_only();
    test_mul();
    test_branch_load_use();
    test_reset_mid_mul();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
